// File: rtl/corr_readout_sched.sv
// Correlation readout scheduler: round-robin arbitration over cseen, bus reads of Cnt/Low/High, Status clear, record out.
// Build with OVERRUN_DETECT_EN defined to add sticky per-channel overrun flags (ovr, ovr_clr).
module corr_readout_sched #(
  parameter int NCH = 32,
  parameter logic [15:0] CORR_BASE = 16'h0600,
  localparam int CW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  cseen,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic [31:0]     addr,
  output logic            read,
  output logic            write,
  output logic [31:0]     Wdata,
  input  logic [31:0]     Rdata,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CW-1:0]   res_chan,
  output logic [31:0]     res_cnt,
  output logic [63:0]     res_corr,
  output logic            busy,
  output logic [2:0]      state
`ifdef OVERRUN_DETECT_EN
  ,
  output logic [NCH-1:0]  ovr,
  input  logic            ovr_clr
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_RD_CNT = 3'd2;
  localparam logic [2:0] S_RD_LO  = 3'd3;
  localparam logic [2:0] S_RD_HI  = 3'd4;
  localparam logic [2:0] S_CLR    = 3'd5;
  localparam logic [2:0] S_OUT    = 3'd6;

  logic [2:0]     st;
  logic [CW-1:0]  chan;
  logic [CW-1:0]  rr;
  logic [CW-1:0]  win;
  logic [CW-1:0]  rr_next;
  logic [CW:0]    sum;
  logic [CW:0]    nx;
  logic           win_found;
  logic [NCH-1:0] inflight;
  logic [NCH-1:0] pending;
  logic [31:0]    cnt_q;
  logic [31:0]    lo_q;
  logic [31:0]    hi_q;
  logic [3:0]     off;
  logic           on_bus;

  assign pending = cseen & ~inflight;

  // Scan from the top so the lowest offset from rr is the last (winning) assignment.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    sum       = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      sum = {1'b0, rr} + (CW+1)'(i);
      if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
      if (pending[sum[CW-1:0]]) begin
        win       = sum[CW-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign nx      = {1'b0, win} + (CW+1)'(1);
  assign rr_next = (nx == (CW+1)'(NCH)) ? '0 : nx[CW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= S_IDLE;
      chan     <= '0;
      rr       <= '0;
      inflight <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      case (st)
        S_IDLE: if (|pending) st <= S_REQ;
        S_REQ: begin
          if (bus_gnt) begin
            if (win_found) begin
              chan     <= win;
              rr       <= rr_next;
              inflight <= NCH'(1) << win;
              st       <= S_RD_CNT;
            end else begin
              st <= S_IDLE;
            end
          end
        end
        S_RD_CNT, S_RD_LO, S_RD_HI, S_CLR: begin
          // Losing the grant mid-access abandons the event; cseen stays set so it is re-served.
          if (!bus_gnt) begin
            st       <= S_IDLE;
            inflight <= '0;
          end else begin
            case (st)
              S_RD_CNT: begin cnt_q <= Rdata; st <= S_RD_LO; end
              S_RD_LO:  begin lo_q  <= Rdata; st <= S_RD_HI; end
              S_RD_HI:  begin hi_q  <= Rdata; st <= S_CLR;   end
              default:  begin inflight <= '0; st <= S_OUT;   end
            endcase
          end
        end
        // Record stream: a transfer happens on a cycle with res_valid & res_ready both high;
        // res_valid never drops and the record never changes until that transfer.
        S_OUT: if (res_ready) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    off = 4'h0;
    case (st)
      S_RD_LO: off = 4'h4;
      S_RD_HI: off = 4'h8;
      S_CLR:   off = 4'hC;
      default: off = 4'h0;
    endcase
  end

  assign on_bus    = (st == S_REQ) || (st == S_RD_CNT) || (st == S_RD_LO) ||
                     (st == S_RD_HI) || (st == S_CLR);
  assign bus_req   = on_bus;
  assign read      = bus_gnt && ((st == S_RD_CNT) || (st == S_RD_LO) || (st == S_RD_HI));
  assign write     = bus_gnt && (st == S_CLR);
  assign addr      = (read || write) ?
                     {16'h0000, CORR_BASE + {{(12-CW){1'b0}}, chan, 4'h0} + {12'h000, off}} : 32'h0;
  assign Wdata     = 32'h0;
  assign res_valid = (st == S_OUT);
  assign res_chan  = chan;
  assign res_cnt   = cnt_q;
  assign res_corr  = {hi_q, lo_q};
  assign busy      = (st != S_IDLE);
  assign state     = st;

`ifdef OVERRUN_DETECT_EN
  localparam int AGE_W = 13;
  localparam logic [AGE_W-1:0] AGE_LIM = 13'd4096;

  logic [NCH-1:0]   cseen_q;
  logic [NCH-1:0]   ovr_set;
  logic [AGE_W-1:0] age [NCH];

  // age reaching the limit means the flag has already waited 4096 cycles ungranted.
  always_comb begin
    ovr_set = '0;
    for (int c = 0; c < NCH; c++) begin
      ovr_set[c] = (cseen[c] && !cseen_q[c] && inflight[c]) ||
                   (cseen[c] && !inflight[c] && (age[c] == AGE_LIM));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cseen_q <= '0;
      ovr     <= '0;
      for (int c = 0; c < NCH; c++) age[c] <= '0;
    end else begin
      cseen_q <= cseen;
      ovr     <= (ovr_clr ? '0 : ovr) | ovr_set;
      for (int c = 0; c < NCH; c++) begin
        if (!cseen[c] || inflight[c]) age[c] <= '0;
        else if (age[c] != AGE_LIM)   age[c] <= age[c] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_corr_readout_sched.sv
// Bench for corr_readout_sched: register-bank bus model, record scoreboard, vector table and corner sequences.
module tb_corr_readout_sched;
  localparam int NCH = 32;
  localparam int CW  = 5;
  localparam int RW  = CW + 96;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NCH-1:0]  cseen;
  logic            bus_req;
  logic            bus_gnt;
  logic [31:0]     addr;
  logic            read;
  logic            write;
  logic [31:0]     Wdata;
  logic [31:0]     Rdata;
  logic            res_valid;
  logic            res_ready;
  logic [CW-1:0]   res_chan;
  logic [31:0]     res_cnt;
  logic [63:0]     res_corr;
  logic            busy;
  logic [2:0]      dbg_state;
`ifdef OVERRUN_DETECT_EN
  logic [NCH-1:0]  ovr;
  logic            ovr_clr;
`endif

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  corr_readout_sched dut (
    .clk(clk), .rst(rst), .cseen(cseen), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr(addr), .read(read), .write(write), .Wdata(Wdata), .Rdata(Rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_cnt(res_cnt), .res_corr(res_corr), .busy(busy), .state(dbg_state)
`ifdef OVERRUN_DETECT_EN
    , .ovr(ovr), .ovr_clr(ovr_clr)
`endif
  );

  // register bank model
  logic [31:0] cnt_m [NCH];
  logic [31:0] lo_m  [NCH];
  logic [31:0] hi_m  [NCH];
  logic [15:0] rd_rel;
  assign rd_rel = addr[15:0] - 16'h0600;
  always_comb begin
    Rdata = 32'h0;
    if (read && addr[31:16] == 16'h0 && rd_rel < 16'(NCH * 16)) begin
      case (rd_rel[3:0])
        4'h0:    Rdata = cnt_m[rd_rel[8:4]];
        4'h4:    Rdata = lo_m[rd_rel[8:4]];
        4'h8:    Rdata = hi_m[rd_rel[8:4]];
        default: Rdata = 32'hbad0bad0;
      endcase
    end
  end

  // scoreboard and bookkeeping
  logic [RW-1:0] exp_q[$];
  logic [16:0]   log_q[$];
  int n_tests = 0, n_fail = 0, n_xfer = 0, n_reads = 0;
  int busy_rise = 0, valid_rise = 0, m_rr = 0, req_cnt = 0, gnt_dly = 0;
  bit gnt_auto = 1'b1, clr_pend = 1'b0, valid_q = 1'b0, busy_q = 1'b0, xfer_q = 1'b0;
  logic [CW-1:0] clr_ch;
  logic [RW-1:0] rec_q;

  typedef struct {
    int          ch;
    logic [31:0] cnt;
    logic [31:0] lo;
    logic [31:0] hi;
    int          gdly;
    logic [63:0] exp_corr;
    logic [15:0] exp_base;
    int          exp_lat;
  } vec_t;
  vec_t vt[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int ch);
    exp_q.push_back({CW'(ch), cnt_m[ch], hi_m[ch], lo_m[ch]});
    m_rr = (ch + 1) % NCH;
  endtask

  task automatic observe();
    logic [15:0] rel;
    if (read || write) begin
      check("strobe_excl", 128'(read && write), 128'(0));
      check("strobe_req_gnt", {bus_req, bus_gnt}, 2'b11);
      check("addr_upper", addr[31:16], 16'h0);
      log_q.push_back({write, addr[15:0]});
      if (read) n_reads++;
    end
    if (write) begin
      check("wdata", Wdata, 32'h0);
      rel      = addr[15:0] - 16'h0600;
      clr_ch   = rel[8:4];
      clr_pend = 1'b1;
    end
    if (res_valid && valid_q && !xfer_q)
      check("rec_stable", {res_chan, res_cnt, res_corr}, rec_q);
    if (busy && !busy_q) busy_rise = cyc;
    if (res_valid && !valid_q) valid_rise = cyc;
    if (res_valid && res_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rec: got 0x%0h, expected none", {res_chan, res_cnt, res_corr});
      end else begin
        check("record", {res_chan, res_cnt, res_corr}, exp_q.pop_front());
      end
    end
    valid_q = res_valid;
    busy_q  = busy;
    xfer_q  = res_valid && res_ready;
    rec_q   = {res_chan, res_cnt, res_corr};
  endtask

  // driver: one clock, with status-clear and grant model applied just after the edge
  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    if (clr_pend) begin
      cseen[clr_ch] = 1'b0;
      clr_pend = 1'b0;
    end
    if (gnt_auto) begin
      if (bus_req) req_cnt++;
      else         req_cnt = 0;
      bus_gnt = bus_req && (req_cnt > gnt_dly);
    end
  endtask

  task automatic wait_xfer(input int target, input int budget, input string name);
    int n = 0;
    while (n_xfer < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 128'(n_xfer >= target), 128'(1));
  endtask

  initial begin #500000; $display("FAIL watchdog: got timeout, expected finish"); $fatal(1); end

  initial begin
    int n, nr, x0, start;
    vt[0] = '{27, 32'h10,       32'h55,       32'h2,        0, 64'h0000000200000055, 16'h07b0, 5};
    vt[1] = '{0,  32'hffffffff, 32'h0,        32'hffffffff, 7, 64'hffffffff00000000, 16'h0600, 12};
    vt[2] = '{31, 32'h1234,     32'hdeadbeef, 32'hcafef00d, 0, 64'hcafef00ddeadbeef, 16'h07f0, 5};
    vt[3] = '{13, 32'h0,        32'ha5a5a5a5, 32'h5a5a5a5a, 2, 64'h5a5a5a5aa5a5a5a5, 16'h06d0, 7};
    vt[4] = '{1,  32'h7,        32'h1,        32'h0,        1, 64'h0000000000000001, 16'h0610, 6};

    cseen = '0; bus_gnt = 1'b0; res_ready = 1'b1;
`ifdef OVERRUN_DETECT_EN
    ovr_clr = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin
      cnt_m[c] = $urandom; lo_m[c] = $urandom; hi_m[c] = $urandom;
    end

    // reset state
    repeat (3) tick();
    check("reset_ctl", {bus_req, read, write, res_valid, busy, dbg_state}, 8'h0);
    check("reset_addr", {addr, Wdata}, 64'h0);
    check("reset_rec", {res_chan, res_cnt, res_corr}, 128'h0);
    rst = 1'b1;
    tick();

    // round robin from rr=0, then a second round, then every channel at once
    cseen[0] = 1'b1; cseen[5] = 1'b1; cseen[31] = 1'b1;
    push_exp(0); push_exp(5); push_exp(31);
    wait_xfer(n_xfer + 3, 100, "rr_round1");
    cseen[0] = 1'b1; cseen[5] = 1'b1;
    push_exp(0); push_exp(5);
    wait_xfer(n_xfer + 2, 80, "rr_round2");
    start = m_rr;
    cseen = '1;
    for (int i = 0; i < NCH; i++) push_exp((start + i) % NCH);
    wait_xfer(n_xfer + NCH, NCH * 12, "rr_all");
    check("rr_all_cleared", cseen, 32'h0);

    // single-event vectors: record, strobe addresses, latency from detect to valid
    foreach (vt[k]) begin
      cnt_m[vt[k].ch] = vt[k].cnt; lo_m[vt[k].ch] = vt[k].lo; hi_m[vt[k].ch] = vt[k].hi;
      gnt_dly = vt[k].gdly;
      log_q.delete();
      exp_q.push_back({CW'(vt[k].ch), vt[k].cnt, vt[k].exp_corr});
      m_rr = (vt[k].ch + 1) % NCH;
      cseen[vt[k].ch] = 1'b1;
      wait_xfer(n_xfer + 1, 60, "vec_done");
      check("vec_latency", 128'(valid_rise - busy_rise), 128'(vt[k].exp_lat));
      check("vec_nstrobe", 128'(log_q.size()), 128'(4));
      for (int j = 0; j < 4; j++)
        check("vec_addr", (log_q.size() > j) ? log_q[j] : 17'h1ffff,
              {(j == 3), vt[k].exp_base + 16'(4 * j)});
    end
    gnt_dly = 0;

    // backpressure: record held, no new arbitration while ch3 waits
    res_ready = 1'b0;
    cseen[8] = 1'b1; push_exp(8);
    n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    check("bp_valid", res_valid, 1'b1);
    cseen[3] = 1'b1; push_exp(3);
    nr = n_reads;
    repeat (20) begin
      tick();
      check("bp_hold", {res_valid, bus_req, busy}, 3'b101);
    end
    check("bp_no_read", 128'(n_reads), 128'(nr));
    res_ready = 1'b1;
    wait_xfer(n_xfer + 2, 40, "bp_done");

    // grant dropped in RD_LO: abort, no record, retried later
    gnt_auto = 1'b0; bus_gnt = 1'b0;
    cseen[20] = 1'b1; push_exp(20);
    x0 = n_xfer;
    n = 0;
    while (!bus_req && n < 10) begin tick(); n++; end
    bus_gnt = 1'b1;
    nr = n_reads; n = 0;
    while (n_reads == nr && n < 10) begin tick(); n++; end
    bus_gnt = 1'b0;
    tick();
    check("abort_reads", 128'(n_reads - nr), 128'(1));
    check("abort_idle", {busy, bus_req, res_valid}, 3'b000);
    check("abort_no_rec", 128'(n_xfer), 128'(x0));
    req_cnt = 0; gnt_auto = 1'b1;
    wait_xfer(x0 + 1, 40, "abort_retry");

    // asynchronous reset during RD_HI, then full re-service
    cseen[12] = 1'b1;
    nr = n_reads; n = 0;
    while (n_reads < nr + 2 && n < 20) begin tick(); n++; end
    check("rst_pre_read", read, 1'b1);
    #2 rst = 1'b0;
    #1 check("rst_immediate", {read, write, bus_req, res_valid, busy}, 5'b0);
    tick(); tick();
    rst = 1'b1;
    m_rr = 0;
    push_exp(12);
    nr = n_reads;
    wait_xfer(n_xfer + 1, 40, "rst_reserve");
    check("rst_reserve_reads", 128'(n_reads - nr), 128'(3));

`ifdef OVERRUN_DETECT_EN
    check("ovr_init", ovr, 32'h0);
    cseen[9] = 1'b1; push_exp(9);
    nr = n_reads; n = 0;
    while (n_reads == nr && n < 20) begin tick(); n++; end
    cseen[9] = 1'b0; tick();
    cseen[9] = 1'b1; tick();
    check("ovr_set", ovr, 32'h1 << 9);
    wait_xfer(n_xfer + 1, 40, "ovr_rec");
    repeat (3) tick();
    check("ovr_sticky", ovr, 32'h1 << 9);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", ovr, 32'h0);
`endif

    repeat (3) tick();
    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_readout_sched.md
Name: corr_readout_sched

Overview:
- Correlation readout scheduler for the spread-spectrum correlator array.
- Watches per-channel correlation-seen flags and round-robin arbitrates among pending channels.
- For the granted channel, masters the shared register bus: reads Correlation Cnt/Low/High, then clears Status.
- Delivers one result record per event on a valid/ready stream to the host-side buffer.

Parameters:
NCH, 32, number of correlator channels (cseen width); channel index width CW = clog2(NCH).
CORR_BASE, 16'h0600, base of correlation register bank; channel c bank = CORR_BASE + 16*c (+0 Cnt, +4 Low, +8 High, +C Status).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
cseen  in  NCH  per-channel correlation-seen flags, level
bus_req  out  1  request for shared register bus
bus_gnt  in  1  bus granted by host; must stay high while bus_req is high
addr  out  32  bus address, upper 16 bits always 0
read  out  1  bus read strobe
write  out  1  bus write strobe
Wdata  out  32  write data, always 0
Rdata  in  32  combinational read data, valid in the cycle read=1
res_valid  out  1  result record valid
res_ready  in  1  consumer ready
res_chan  out  CW  channel of record
res_cnt  out  32  Correlation Cnt
res_corr  out  64  {High,Low} correlation sum
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0): all outputs 0, FSM IDLE, rr pointer 0, all record registers 0.
- pending = cseen & ~inflight_mask. inflight_mask bit is set on grant and cleared on the CLR write.
- IDLE: if pending != 0, assert bus_req and go to REQ.
- REQ: hold bus_req. When bus_gnt=1, latch the winner and go to RD_CNT.
  - Winner = first set bit of pending at or after rr pointer, wrapping NCH-1 -> 0.
  - Set rr = winner+1 mod NCH.
- RD_CNT, RD_LO, RD_HI: one cycle each.
  - read=1, addr = CORR_BASE + 16*chan + {0,4,8}.
  - Rdata captured at the end of the same cycle into cnt/low/high.
- CLR: one cycle, write=1, addr = bank+C, Wdata=0. Clears the channel's Status and therefore its cseen.
  - Drop bus_req in the same cycle. Go to OUT.
- OUT: res_valid=1 with record held stable until res_ready=1; transfer occurs on valid&ready.
  - Then IDLE, with res_valid=0 the next cycle.
  - No new arbitration while OUT is waiting on backpressure.
- Latency with no contention: bus_gnt in the REQ cycle gives res_valid 5 cycles after IDLE detects pending (REQ, RD_CNT, RD_LO, RD_HI, CLR, then OUT).
- read and write are never both 1. bus_req is high only in REQ through CLR.
- If bus_gnt drops during RD_*/CLR (protocol violation): abort to IDLE, release bus, clear inflight bit, emit no record. The channel is re-served later because cseen stays set.
- A channel's cseen re-asserting after CLR is a new event.
- Simultaneous pending on all channels: served strictly in rr order, each exactly once per round.
- Reset mid-transaction: immediate return to reset state; no bus strobe is emitted after rst falls.

Optional Feature:
- Macro OVERRUN_DETECT_EN.
- When defined:
  - Adds output ovr (NCH bits) and input ovr_clr (1 bit).
  - ovr[c] sets when cseen[c] has a rising edge while channel c is inflight.
  - ovr[c] also sets when cseen[c] stays set for more than 4096 cycles without being granted.
  - ovr bits are sticky until ovr_clr=1 (clears all); set takes priority over clear in the same cycle.
- When undefined: no ovr/ovr_clr ports and no edge/age logic.

Test Plan:
- Single event: cseen[27]=1, bus_gnt tied 1, Rdata model returns 0x10/0x55/0x2 -> reads at 0x7b0/0x7b4/0x7b8, write 0 to 0x7bc, then res_chan=27, res_cnt=0x10, res_corr=0x0000000200000055, res_valid 5 cycles after detect.
- Round robin: cseen[0],[5],[31] all set and held, each cleared by its CLR write -> service order 0,5,31; then set [0],[5] again with rr=0 -> 0 then 5.
- Backpressure: res_ready=0 for 20 cycles while cseen[3] is pending -> record held stable, no bus_req, no new read; after ready the record transfers once, then channel 3 is served.
- Grant delay/abort: bus_gnt low for 7 cycles -> bus_req held, no strobes. Drop gnt in RD_LO -> IDLE, no record, channel retried later.
- Async reset in RD_HI -> read, write, bus_req, res_valid all 0 immediately; after release, a still-pending channel is fully re-served from RD_CNT.
- With OVERRUN_DETECT_EN: pulse cseen[9] low-high while ch9 is inflight -> ovr[9]=1, stays 1 until ovr_clr.
